wb_rom_arbiter: RTL and testbench

//  Two-master to one-slave Wishbone (classic, read-only) arbiter sharing the boot/program ROM slave.
//  M0 = instruction fetch port, M1 = data load port of the CPU; S = ROM slave (registered ack, 1 wait).

---
 rtl/wb_rom_arbiter_pkg.sv | 22 ++
 rtl/wb_arb_pick.sv | 29 ++
 rtl/wb_rom_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_rom_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_rom_arbiter_pkg.sv
// Shared definitions for the two-master Wishbone ROM arbiter:
// FSM state encodings, grant identifiers and the default watchdog timeout.
package wb_rom_arbiter_pkg;

    // FSM state encodings (legacy-compatible plain constants)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    // Default number of STB-without-ACK cycles before a cycle is aborted
    localparam int TIMEOUT_DEFAULT = 16;

    // Encoding of the last_gnt bit
    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    // Map a master index onto its grant state
    function automatic logic [1:0] gnt_state(input logic idx);
        return (idx == GNT_M1) ? ST_GNT1 : ST_GNT0;
    endfunction

endpackage

// File: rtl/wb_arb_pick.sv
// Combinational tie-break for the Wishbone ROM arbiter.
// Build option: WB_ARB_ROUND_ROBIN_EN
//   defined     - simultaneous requests go to the master that did not own the last tenure
//   not defined - fixed priority, M0 always wins a tie (last_gnt ignored)
// At most one of gnt0/gnt1 is ever high.
module wb_arb_pick
    import wb_rom_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_gnt,
    output logic gnt0,
    output logic gnt1
);

`ifdef WB_ARB_ROUND_ROBIN_EN
    // A lone request always wins; on a tie the master that was not last served wins
    assign gnt0 = req0 & (~req1 | (last_gnt == GNT_M1));
    assign gnt1 = req1 & (~req0 | (last_gnt == GNT_M0));
`else
    logic unused_last_gnt;

    // Fixed priority: M0 beats M1 whenever both ask
    assign gnt0 = req0;
    assign gnt1 = req1 & ~req0;
    assign unused_last_gnt = last_gnt;
`endif

endmodule

// File: rtl/wb_rom_arbiter.sv
// Two-master to one-slave Wishbone classic (read-only) arbiter for the shared boot/program ROM.
// M0 = instruction fetch, M1 = data load. The winning master keeps the slave for as long as it
// holds CYC; a watchdog aborts a tenure whose strobe goes unanswered for TIMEOUT cycles.
// Build option: WB_ARB_ROUND_ROBIN_EN selects round-robin tie-break (see wb_arb_pick),
// otherwise M0 has fixed priority.
module wb_rom_arbiter
    import wb_rom_arbiter_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int CNT_W   = 5
) (
    input  logic             clk,
    input  logic             rst,
    // master 0 (instruction fetch)
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    output logic [31:0]      m0_dat_o,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    // master 1 (data load)
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    output logic [31:0]      m1_dat_o,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    // ROM slave
    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic [ADR_W-1:0] s_adr_o,
    input  logic [31:0]      s_dat_i,
    input  logic             s_ack_i
);

    // Counter value on which the watchdog fires
    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state_q, state_d;
    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;

    logic req0, req1;
    logic pick0, pick1;
    logic granted;      // a master currently owns the slave
    logic gnt_idx;      // which master owns it (valid when granted)
    logic gnt_cyc;      // owner's CYC
    logic gnt_stb;      // owner's STB
    logic wd_expire;    // abort the current tenure this cycle

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    wb_arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_gnt (last_gnt_q),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    assign granted = (state_q == ST_GNT0) || (state_q == ST_GNT1);
    assign gnt_idx = (state_q == ST_GNT1) ? GNT_M1 : GNT_M0;
    assign gnt_cyc = granted & ((gnt_idx == GNT_M1) ? m1_cyc_i : m0_cyc_i);
    assign gnt_stb = granted & ((gnt_idx == GNT_M1) ? m1_stb_i : m0_stb_i);

    // A late ack on the expiry cycle wins: the transfer completes and no error is raised
    assign wd_expire = gnt_stb & ~s_ack_i & (wd_cnt_q == WD_LAST);

    // Route the owning master to the slave and the slave response back to it only
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_adr_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        case (state_q)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_adr_o  = m0_adr_i;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i;
                m0_err_o = wd_expire;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_adr_o  = m1_adr_i;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i;
                m1_err_o = wd_expire;
            end
            default: ;
        endcase
    end

    // Next-state logic: grant from IDLE, hold while CYC is up, release on CYC drop or watchdog
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        wd_cnt_d   = wd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // counter is held at zero here, so every tenure starts from a clean count
                wd_cnt_d = '0;
                if (pick0 | pick1) begin
                    state_d = gnt_state(pick1);
                end
            end
            ST_GNT0, ST_GNT1: begin
                if (!gnt_cyc || wd_expire) begin
                    // release; the mandatory IDLE cycle follows
                    state_d    = ST_IDLE;
                    last_gnt_d = gnt_idx;
                    wd_cnt_d   = '0;
                end else if (s_ack_i) begin
                    wd_cnt_d = '0;
                end else if (gnt_stb) begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                wd_cnt_d = '0;
            end
        endcase
    end

    // State, arbitration history and watchdog registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            last_gnt_q <= GNT_M1;
            wd_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            wd_cnt_q   <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rom_arbiter.sv
// Directed testbench for wb_rom_arbiter with a registered-ack (1 wait state) ROM model.
// ROM word at byte address a is 32'hA000_0000 | (a >> 2).
module tb_wb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cyc, m0_stb, m1_cyc, m1_stb;
    logic [31:0] m0_adr, m1_adr;
    logic [31:0] m0_dat, m1_dat;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic        s_cyc, s_stb, s_ack;
    logic [31:0] s_adr, s_dat;

    logic        rom_ack_en;
    logic        rom_ack_q;
    logic [31:0] rom_dat_q;
    logic        force_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_rom_arbiter #(.ADR_W(32), .TIMEOUT(16), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_cyc_i (m0_cyc),
        .m0_stb_i (m0_stb),
        .m0_adr_i (m0_adr),
        .m0_dat_o (m0_dat),
        .m0_ack_o (m0_ack),
        .m0_err_o (m0_err),
        .m1_cyc_i (m1_cyc),
        .m1_stb_i (m1_stb),
        .m1_adr_i (m1_adr),
        .m1_dat_o (m1_dat),
        .m1_ack_o (m1_ack),
        .m1_err_o (m1_err),
        .s_cyc_o  (s_cyc),
        .s_stb_o  (s_stb),
        .s_adr_o  (s_adr),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack)
    );

    // ROM slave: one wait state, single-cycle ack pulse
    always @(posedge clk) begin
        if (rst) begin
            rom_ack_q <= 1'b0;
            rom_dat_q <= '0;
        end else begin
            rom_ack_q <= s_cyc & s_stb & ~rom_ack_q & rom_ack_en;
            rom_dat_q <= 32'hA000_0000 | (s_adr >> 2);
        end
    end
    assign s_dat = rom_dat_q;
    assign s_ack = rom_ack_q | force_ack;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int acks;
        int errs;
        int first_err;
        logic m0_seen;
        logic [31:0] last_dat;

        rst = 1'b1;
        m0_cyc = 0; m0_stb = 0; m0_adr = '0;
        m1_cyc = 0; m1_stb = 0; m1_adr = '0;
        rom_ack_en = 1'b1;
        force_ack  = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_s_adr", s_adr, 0);
        check("rst_m0_ack", m0_ack, 0);
        check("rst_m1_ack", m1_ack, 0);
        check("rst_m0_err", m0_err, 0);
        check("rst_m1_err", m1_err, 0);
        check("rst_m0_dat", m0_dat, 0);
        check("rst_m1_dat", m1_dat, 0);
        rst = 1'b0;
        tick();

        // 1: single M0 read of 0x10
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0010;
        tick();
        check("t1_s_stb_c1", s_stb, 1);
        check("t1_s_adr_c1", s_adr, 32'h0000_0010);
        check("t1_m0_ack_c1", m0_ack, 0);
        tick();
        check("t1_m0_ack_c2", m0_ack, 1);
        check("t1_m0_dat_c2", m0_dat, 32'hA000_0004);
        check("t1_m1_ack_c2", m1_ack, 0);
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();
        check("t1_idle_s_cyc", s_cyc, 0);

        // 2: simultaneous requests after reset
        do_reset();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0020;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0040;
        tick();
        check("t2_first_tie_adr", s_adr, 32'h0000_0020);
        tick();
        check("t2_first_m0_ack", m0_ack, 1);
        check("t2_first_m1_ack", m1_ack, 0);
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();
        check("t2_gap_s_cyc", s_cyc, 0);
        m0_cyc = 1; m0_stb = 1;
        tick();
`ifdef WB_ARB_ROUND_ROBIN_EN
        check("t2_second_tie_adr", s_adr, 32'h0000_0040);
        tick();
        check("t2_second_m1_ack", m1_ack, 1);
        check("t2_second_m1_dat", m1_dat, 32'hA000_0010);
        check("t2_second_m0_ack", m0_ack, 0);
`else
        check("t2_second_tie_adr", s_adr, 32'h0000_0020);
        tick();
        check("t2_second_m0_ack", m0_ack, 1);
        check("t2_second_m0_dat", m0_dat, 32'hA000_0008);
        check("t2_second_m1_ack", m1_ack, 0);
`endif
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        tick();

        // 3: M1 locks the bus for 3 beats while M0 waits
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0008;
        tick();
        check("t3_m1_granted", s_adr, 32'h0000_0008);
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_000C;
        acks = 0;
        m0_seen = 1'b0;
        last_dat = '0;
        for (int c = 0; c < 20 && acks < 3; c++) begin
            tick();
            if (m1_ack) begin
                acks++;
                last_dat = m1_dat;
            end
            if (m0_ack || m0_err) m0_seen = 1'b1;
        end
        check("t3_m1_acks", acks, 3);
        check("t3_m1_dat", last_dat, 32'hA000_0002);
        check("t3_m0_starved_quiet", m0_seen, 0);
        tick();
        m1_cyc = 0; m1_stb = 0;
        tick();
        check("t3_gap_s_cyc", s_cyc, 0);
        check("t3_gap_m0_ack", m0_ack, 0);
        tick();
        check("t3_m0_granted_cyc", s_cyc, 1);
        check("t3_m0_granted_adr", s_adr, 32'h0000_000C);
        tick();
        check("t3_m0_ack", m0_ack, 1);
        check("t3_m0_dat", m0_dat, 32'hA000_0003);
        tick();
        m0_cyc = 0; m0_stb = 0;
        tick();

        // 4: slave never acks, watchdog aborts the tenure
        rom_ack_en = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0100;
        errs = 0;
        first_err = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (m0_err) begin
                errs++;
                if (first_err == 0) first_err = c;
            end
            if (c == 17) begin
                check("t4_abort_idle", s_cyc, 0);
                m0_cyc = 0; m0_stb = 0;
            end
        end
        check("t4_err_count", errs, 1);
        check("t4_err_cycle", first_err, 16);
        rom_ack_en = 1'b1;

        // 5: reset during an M1 tenure
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h0000_0030;
        tick();
        check("t5_m1_granted", s_adr, 32'h0000_0030);
        rst = 1'b1;
        tick();
        check("t5_rst_s_cyc", s_cyc, 0);
        check("t5_rst_m0_ack", m0_ack, 0);
        check("t5_rst_m1_ack", m1_ack, 0);
        rst = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0034;
        tick();
        check("t5_tie_after_rst", s_adr, 32'h0000_0034);
        tick();
        check("t5_m0_ack", m0_ack, 1);
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
        tick();
        tick();

        // 6: ack arrives on the expiry cycle
        rom_ack_en = 1'b0;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h0000_0200;
        errs = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            if (m0_err) errs++;
        end
        check("t6_no_early_err", errs, 0);
        tick();
        force_ack = 1'b1;
        #1;
        check("t6_expiry_ack", m0_ack, 1);
        check("t6_expiry_err", m0_err, 0);
        tick();
        force_ack = 1'b0;
        #1;
        check("t6_grant_kept", s_cyc, 1);
        check("t6_err_after", m0_err, 0);
        m0_cyc = 0; m0_stb = 0;
        tick();
        check("t6_release", s_cyc, 0);
        rom_ack_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
